// File: rtl/spm_arb_pkg.sv
// Shared definitions for the scratch-pad port arbiter: port ids, sizing helpers
// and the per-port request bundle.
package spm_arb_pkg;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Number of byte-address bits that index inside the SPM.
  function automatic int spmMaxBit(input int sizeInBytes);
    return clog2(sizeInBytes);
  endfunction

  // Starve counter width; at least one bit so maxWaitCycles=0 still elaborates.
  function automatic int starveCounterWidth(input int maxWait);
    return (maxWait < 1) ? 1 : clog2(maxWait + 1);
  endfunction

  typedef struct packed {
    logic        request;
    logic        we;
    logic [3:0]  byteEnables;
    logic [31:0] address;
    logic [31:0] weData;
  } spmRequest_t;

endpackage

// File: rtl/spm_arb_starve_counter.sv
// Saturating wait counter for one arbiter port. Reports when the port has
// waited maxValue consecutive cycles and must be forced to win.
module spm_arb_starve_counter #(
  parameter int maxValue     = 4,
  parameter int counterWidth = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic increment,
  output logic saturated
);

  localparam logic [counterWidth-1:0] maxCount = counterWidth'(maxValue);

  logic [counterWidth-1:0] count;

  // Count busy cycles, stick at the limit, restart on grant or dropped request.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (increment && (count != maxCount)) begin
      count <= count + counterWidth'(1);
    end
  end

  assign saturated = (count == maxCount);

endmodule

// File: rtl/spm_port_arbiter.sv
// Shares the single-port SPM RAM between the CPU data port and the SPM DMA.
// One grant per cycle, loser back-pressured through busy, 1-cycle read return
// routed to the owner, out-of-range / misaligned accesses flagged.
module spm_port_arbiter
  import spm_arb_pkg::*;
#(
  parameter logic [31:0] spmBaseAddress = 32'hC0000000,
  parameter int          spmSizeInBytes = 8 * 1024,
  parameter int          maxWaitCycles  = 4,
  localparam int         maxBit         = spmMaxBit(spmSizeInBytes)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpuRequest,
  input  logic              cpuWe,
  input  logic [3:0]        cpuByteEnables,
  input  logic [31:0]       cpuAddress,
  input  logic [31:0]       cpuWeData,
  output logic              cpuBusy,
  output logic [31:0]       cpuReData,
  output logic              cpuReDataValid,
  input  logic              dmaRequest,
  input  logic              dmaWe,
  input  logic [31:0]       dmaAddress,
  input  logic [31:0]       dmaWeData,
  output logic              dmaBusy,
  output logic [31:0]       dmaReData,
  output logic              dmaReDataValid,
  output logic [maxBit-3:0] ramAddress,
  output logic              ramWe,
  output logic [3:0]        ramByteEnables,
  output logic [31:0]       ramWeData,
  input  logic [31:0]       ramReData,
  output logic              rangeError,
  output logic              errorPort
);

  localparam int cntWidth = starveCounterWidth(maxWaitCycles);

  spmRequest_t [NUM_PORTS-1:0] portReq;
  logic [NUM_PORTS-1:0] activeReq;
  logic [NUM_PORTS-1:0] saturated;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] busy;

  logic        winner;
  logic        anyGrant;
  logic        addrOk;
  logic        lastGrant;
  logic        grantSeen;
  logic        readPending;
  logic        readOwner;
  logic        readRejected;
  logic [31:0] returnData;

  // DMA always moves whole words.
  assign portReq[PORT_CPU] = '{cpuRequest, cpuWe, cpuByteEnables, cpuAddress, cpuWeData};
  assign portReq[PORT_DMA] = '{dmaRequest, dmaWe, 4'hF, dmaAddress, dmaWeData};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign activeReq[p] = portReq[p].request & ~reset;
    assign busy[p]      = reset | (portReq[p].request & ~grant[p]);

    spm_arb_starve_counter #(
      .maxValue    (maxWaitCycles),
      .counterWidth(cntWidth)
    ) starveCnt (
      .clock    (clock),
      .reset    (reset),
      .clear    (~portReq[p].request | grant[p]),
      .increment(portReq[p].request & busy[p]),
      .saturated(saturated[p])
    );
  end

  // Winner select: CPU by default, a starved port overrides, and when both are
  // starved the port not granted last wins. Until the first grant after reset
  // there is no "last" port, so the CPU takes the tie.
  always_comb begin
    winner = PORT_CPU;
    if (activeReq[PORT_CPU] && activeReq[PORT_DMA]) begin
      if (saturated[PORT_CPU] && saturated[PORT_DMA]) begin
        winner = (grantSeen && (lastGrant == PORT_CPU)) ? PORT_DMA : PORT_CPU;
      end else if (saturated[PORT_DMA]) begin
        winner = PORT_DMA;
      end
    end else if (activeReq[PORT_DMA]) begin
      winner = PORT_DMA;
    end
  end

  assign anyGrant        = |activeReq;
  assign grant[PORT_CPU] = anyGrant & (winner == PORT_CPU);
  assign grant[PORT_DMA] = anyGrant & (winner == PORT_DMA);
  assign cpuBusy         = busy[PORT_CPU];
  assign dmaBusy         = busy[PORT_DMA];

  // A rejected access keeps its slot but never writes the RAM.
  assign addrOk = (portReq[winner].address[31:maxBit] == spmBaseAddress[31:maxBit]) &&
                  (portReq[winner].address[1:0] == 2'b00);

  assign ramAddress     = anyGrant ? portReq[winner].address[maxBit-1:2] : '0;
  assign ramWe          = anyGrant & addrOk & portReq[winner].we;
  assign ramByteEnables = anyGrant ? portReq[winner].byteEnables : 4'h0;
  assign ramWeData      = anyGrant ? portReq[winner].weData : 32'd0;

  // Track the outstanding read, error reporting and tie-break history.
  always_ff @(posedge clock) begin
    if (reset) begin
      readPending  <= 1'b0;
      readOwner    <= PORT_CPU;
      readRejected <= 1'b0;
      rangeError   <= 1'b0;
      errorPort    <= PORT_CPU;
      lastGrant    <= PORT_CPU;
      grantSeen    <= 1'b0;
    end else begin
      readPending  <= anyGrant & ~portReq[winner].we;
      readOwner    <= winner;
      readRejected <= ~addrOk;
      rangeError   <= anyGrant & ~addrOk;
      if (anyGrant && !addrOk) begin
        errorPort <= winner;
      end
      if (anyGrant) begin
        lastGrant <= winner;
        grantSeen <= 1'b1;
      end
    end
  end

  // Reset also masks a read that was granted just before it, so no stray pulse.
  assign returnData     = readRejected ? 32'd0 : ramReData;
  assign cpuReDataValid = readPending & ~reset & (readOwner == PORT_CPU);
  assign dmaReDataValid = readPending & ~reset & (readOwner == PORT_DMA);
  assign cpuReData      = cpuReDataValid ? returnData : 32'd0;
  assign dmaReData      = dmaReDataValid ? returnData : 32'd0;

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Directed bench for spm_port_arbiter: a vector table for single transactions
// plus hand sequences for reset, starvation rotation and reset mid-read.
// A second instance built with maxWaitCycles=0 shares the inputs.
module tb_spm_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpuRequest = 0, cpuWe = 0;
  logic [3:0]  cpuByteEnables = 0;
  logic [31:0] cpuAddress = 0, cpuWeData = 0;
  logic        dmaRequest = 0, dmaWe = 0;
  logic [31:0] dmaAddress = 0, dmaWeData = 0;

  logic        cpuBusy, cpuReDataValid, dmaBusy, dmaReDataValid;
  logic [31:0] cpuReData, dmaReData;
  logic [10:0] ramAddress;
  logic        ramWe, rangeError, errorPort;
  logic [3:0]  ramByteEnables;
  logic [31:0] ramWeData, ramReData;

  logic        bCpuBusy, bCpuReDataValid, bDmaBusy, bDmaReDataValid;
  logic [31:0] bCpuReData, bDmaReData;
  logic [10:0] bRamAddress;
  logic        bRamWe, bRangeError, bErrorPort;
  logic [3:0]  bRamByteEnables;
  logic [31:0] bRamWeData;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  spm_port_arbiter dut (
    .clock(clock), .reset(reset),
    .cpuRequest(cpuRequest), .cpuWe(cpuWe), .cpuByteEnables(cpuByteEnables),
    .cpuAddress(cpuAddress), .cpuWeData(cpuWeData), .cpuBusy(cpuBusy),
    .cpuReData(cpuReData), .cpuReDataValid(cpuReDataValid),
    .dmaRequest(dmaRequest), .dmaWe(dmaWe), .dmaAddress(dmaAddress),
    .dmaWeData(dmaWeData), .dmaBusy(dmaBusy), .dmaReData(dmaReData),
    .dmaReDataValid(dmaReDataValid),
    .ramAddress(ramAddress), .ramWe(ramWe), .ramByteEnables(ramByteEnables),
    .ramWeData(ramWeData), .ramReData(ramReData),
    .rangeError(rangeError), .errorPort(errorPort)
  );

  spm_port_arbiter #(.maxWaitCycles(0)) dutAlt (
    .clock(clock), .reset(reset),
    .cpuRequest(cpuRequest), .cpuWe(cpuWe), .cpuByteEnables(cpuByteEnables),
    .cpuAddress(cpuAddress), .cpuWeData(cpuWeData), .cpuBusy(bCpuBusy),
    .cpuReData(bCpuReData), .cpuReDataValid(bCpuReDataValid),
    .dmaRequest(dmaRequest), .dmaWe(dmaWe), .dmaAddress(dmaAddress),
    .dmaWeData(dmaWeData), .dmaBusy(bDmaBusy), .dmaReData(bDmaReData),
    .dmaReDataValid(bDmaReDataValid),
    .ramAddress(bRamAddress), .ramWe(bRamWe), .ramByteEnables(bRamByteEnables),
    .ramWeData(bRamWeData), .ramReData(32'd0),
    .rangeError(bRangeError), .errorPort(bErrorPort)
  );

  // RAM model: byte-lane writes, registered read, cleared while reset is high.
  logic [31:0] mem [0:2047];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
    end else if (ramWe) begin
      for (int b = 0; b < 4; b++)
        if (ramByteEnables[b]) mem[ramAddress][8*b +: 8] <= ramWeData[8*b +: 8];
    end
    ramReData <= mem[ramAddress];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    cpuRequest = 0; cpuWe = 0; cpuByteEnables = 0; cpuAddress = 0; cpuWeData = 0;
    dmaRequest = 0; dmaWe = 0; dmaAddress = 0; dmaWeData = 0;
  endtask

  typedef struct {
    logic        cReq, cWe;
    logic [3:0]  cBe;
    logic [31:0] cAddr, cData;
    logic        dReq, dWe;
    logic [31:0] dAddr, dData;
    logic        eCpuBusy, eDmaBusy, eRamWe;
    logic [10:0] eRamAddr;
    logic        eCpuVld;
    logic [31:0] eCpuData;
    logic        eDmaVld;
    logic [31:0] eDmaData;
    logic        eErr, eErrPort;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // cReq cWe cBe  cAddr         cData          dReq dWe dAddr         dData          cB dB rWe rAddr   cV cData          dV dData          err port
    vecs[0]  = '{1, 1, 4'hF, 32'hC0000010, 32'h12345678, 0, 0, 32'h0,        32'h0,        0, 0, 1, 11'h004, 0, 32'h0,        0, 32'h0,        0, 0};
    vecs[1]  = '{1, 0, 4'hF, 32'hC0000010, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 11'h004, 1, 32'h12345678, 0, 32'h0,        0, 0};
    vecs[2]  = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'hC0002000, 32'hDEADBEEF, 0, 0, 0, 11'h000, 0, 32'h0,        0, 32'h0,        1, 1};
    vecs[3]  = '{1, 0, 4'hF, 32'hC0000000, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 11'h000, 1, 32'h0,        0, 32'h0,        0, 1};
    vecs[4]  = '{1, 1, 4'hF, 32'hC0000020, 32'h11223344, 0, 0, 32'h0,        32'h0,        0, 0, 1, 11'h008, 0, 32'h0,        0, 32'h0,        0, 1};
    vecs[5]  = '{1, 1, 4'h4, 32'hC0000020, 32'hAABBCCDD, 0, 0, 32'h0,        32'h0,        0, 0, 1, 11'h008, 0, 32'h0,        0, 32'h0,        0, 1};
    vecs[6]  = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'hC0000020, 32'h0,        0, 0, 0, 11'h008, 0, 32'h0,        1, 32'h11BB3344, 0, 1};
    vecs[7]  = '{1, 1, 4'hF, 32'hC0000030, 32'hCAFEF00D, 1, 0, 32'hC0000030, 32'h0,        0, 1, 1, 11'h00C, 0, 32'h0,        0, 32'h0,        0, 1};
    vecs[8]  = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'hC0000030, 32'h0,        0, 0, 0, 11'h00C, 0, 32'h0,        1, 32'hCAFEF00D, 0, 1};
    vecs[9]  = '{1, 0, 4'hF, 32'hC0000032, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 11'h00C, 1, 32'h0,        0, 32'h0,        1, 0};
    vecs[10] = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'hC0000040, 32'h5A5A5A5A, 0, 0, 1, 11'h010, 0, 32'h0,        0, 32'h0,        0, 0};
    vecs[11] = '{1, 0, 4'hF, 32'hC0000040, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 11'h010, 1, 32'h5A5A5A5A, 0, 32'h0,        0, 0};
    vecs[12] = '{1, 1, 4'hF, 32'hD0000000, 32'h01010101, 0, 0, 32'h0,        32'h0,        0, 0, 0, 11'h000, 0, 32'h0,        0, 32'h0,        1, 0};
    vecs[13] = '{0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 11'h000, 0, 32'h0,        0, 32'h0,        0, 0};

    // Reset state
    step(); step();
    check("rst cpuBusy", cpuBusy, 1);
    check("rst dmaBusy", dmaBusy, 1);
    check("rst ramWe", ramWe, 0);
    check("rst cpuVld", cpuReDataValid, 0);
    check("rst dmaVld", dmaReDataValid, 0);
    check("rst rangeError", rangeError, 0);
    check("rst errorPort", errorPort, 0);
    check("rst alt cpuBusy", bCpuBusy, 1);
    check("rst alt dmaBusy", bDmaBusy, 1);
    reset = 0;
    step();

    // Vector table: one transaction cycle, then one idle cycle
    for (int i = 0; i < 14; i++) begin
      cpuRequest = vecs[i].cReq; cpuWe = vecs[i].cWe; cpuByteEnables = vecs[i].cBe;
      cpuAddress = vecs[i].cAddr; cpuWeData = vecs[i].cData;
      dmaRequest = vecs[i].dReq; dmaWe = vecs[i].dWe;
      dmaAddress = vecs[i].dAddr; dmaWeData = vecs[i].dData;
      #3;
      check($sformatf("v%0d cpuBusy", i), cpuBusy, vecs[i].eCpuBusy);
      check($sformatf("v%0d dmaBusy", i), dmaBusy, vecs[i].eDmaBusy);
      check($sformatf("v%0d ramWe", i), ramWe, vecs[i].eRamWe);
      check($sformatf("v%0d ramAddress", i), ramAddress, vecs[i].eRamAddr);
      step();
      idleInputs();
      check($sformatf("v%0d cpuVld", i), cpuReDataValid, vecs[i].eCpuVld);
      check($sformatf("v%0d cpuData", i), cpuReData, vecs[i].eCpuData);
      check($sformatf("v%0d dmaVld", i), dmaReDataValid, vecs[i].eDmaVld);
      check($sformatf("v%0d dmaData", i), dmaReData, vecs[i].eDmaData);
      check($sformatf("v%0d rangeError", i), rangeError, vecs[i].eErr);
      check($sformatf("v%0d errorPort", i), errorPort, vecs[i].eErrPort);
      step();
    end

    // Both ports request continuously from reset release: main build rotates
    // 4 CPU grants then 1 DMA grant; the maxWaitCycles=0 build alternates.
    reset = 1;
    step(); step();
    reset = 0;
    cpuRequest = 1; cpuWe = 0; cpuByteEnables = 4'hF; cpuAddress = 32'hC0000010;
    dmaRequest = 1; dmaWe = 0; dmaAddress = 32'hC0000020;
    for (int k = 0; k < 10; k++) begin
      #3;
      check($sformatf("starve%0d cpuBusy", k), cpuBusy, (k % 5) == 4);
      check($sformatf("starve%0d dmaBusy", k), dmaBusy, (k % 5) != 4);
      check($sformatf("alt%0d cpuBusy", k), bCpuBusy, (k % 2) == 1);
      check($sformatf("alt%0d dmaBusy", k), bDmaBusy, (k % 2) == 0);
      step();
      check($sformatf("starve%0d cpuVld", k), cpuReDataValid, (k % 5) != 4);
      check($sformatf("starve%0d dmaVld", k), dmaReDataValid, (k % 5) == 4);
    end
    idleInputs();
    step();

    // Reset in the cycle after a granted DMA read drops the read
    dmaRequest = 1; dmaWe = 0; dmaAddress = 32'hC0000040;
    #3;
    check("midrst grant dmaBusy", dmaBusy, 0);
    step();
    reset = 1;
    idleInputs();
    #1;
    check("midrst dmaVld", dmaReDataValid, 0);
    check("midrst cpuBusy", cpuBusy, 1);
    check("midrst dmaBusy", dmaBusy, 1);
    check("midrst ramWe", ramWe, 0);
    step();
    check("midrst dmaVld2", dmaReDataValid, 0);
    reset = 0;
    cpuRequest = 1; cpuWe = 0; cpuByteEnables = 4'hF; cpuAddress = 32'hC0000010;
    dmaRequest = 1; dmaWe = 0; dmaAddress = 32'hC0000020;
    #3;
    check("postrst cpuBusy", cpuBusy, 0);
    check("postrst dmaBusy", dmaBusy, 1);
    check("postrst alt cpuBusy", bCpuBusy, 0);
    check("postrst alt dmaBusy", bDmaBusy, 1);
    step();
    check("postrst dmaVld", dmaReDataValid, 0);
    check("postrst cpuVld", cpuReDataValid, 1);
    idleInputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
